ibex_cheri_mem_exc_tracker: RTL and testbench
=============================================

# ibex_cheri_mem_exc_tracker

Downstream companion of the CHERI memory checker. It captures the registered per-request CHERI exception vector and the request address, queues them per outstanding bus transaction, and releases them aligned with the matching `data_rvalid_i` response. The released entry becomes a single prioritised CHERI cause code and faulting address for the LSU/IF error path. It also limits how many requests may be in flight.

## Interface
- `DataMem`, default 1'b1: 1 for the data port; 0 for the instruction port. When 0, store violations are never reported.
- `MaxOutstanding`, default 2: maximum number of in-flight transactions, range 1..4.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `data_req_i`  in  1  bus request, same signal as seen by the checker.
- `data_gnt_i`  in  1  bus grant.
- `data_addr_i`  in  32  request address, sampled on `data_req_i & data_gnt_i`.
- `data_rvalid_i`  in  1  response valid; responses return in order.
- `cheri_mem_exc_i`  in  ibex_pkg::CheriExcWidth  registered exception vector from the checker, valid the cycle after the grant.
- `req_allowed_o`  out  1  high when another grant may be accepted.
- `cheri_err_o`  out  1  the current response carries a CHERI fault.
- `cheri_cause_o`  out  5  CHERI cause code for the current response.
- `cheri_fault_addr_o`  out  32  address of the faulting request.
- `protocol_err_o`  out  1  one-cycle registered pulse on a bus protocol misuse.

## Operation
- **Capture stage.** On `data_req_i & data_gnt_i` in cycle N:
  - latch `data_addr_i` into `pend_addr_q`;
  - set `pend_valid_q`.
- **Push.** In cycle N+1, push {`cheri_mem_exc_i`, `pend_addr_q`} into the FIFO. A new grant in N+1 reloads the capture stage in the same cycle.
- **FIFO.**
  - Depth is `MaxOutstanding`, implemented as a circular buffer with read/write pointers that wrap modulo depth.
  - A simultaneous push and pop is legal at any occupancy, including full.
- **Outstanding count.**
  - `count = FIFO occupancy + pend_valid_q`; width `$clog2(MaxOutstanding+1)`.
  - `count` increments on a grant and decrements on `data_rvalid_i`.
  - `req_allowed_o = (count < MaxOutstanding)`.
- **Response selection on `data_rvalid_i`.**
  - If the FIFO is non-empty, the head entry is used and popped.
  - If the FIFO is empty and an entry is being pushed this cycle, bypass: use {`cheri_mem_exc_i`, `pend_addr_q`} directly and do not write it into the FIFO.
- **Exception masking.** When `DataMem=0`, bit `PERMIT_STORE_VIOLATION` is masked.
- **Cause priority**, highest first:
  - TAG_VIOLATION → 0x02
  - SEAL_VIOLATION → 0x03
  - PERMIT_EXECUTE_VIOLATION → 0x11
  - PERMIT_LOAD_VIOLATION → 0x12
  - PERMIT_STORE_VIOLATION → 0x13
  - LENGTH_VIOLATION → 0x01
- **Response outputs.**
  - `cheri_err_o` = `data_rvalid_i` AND (the selected vector after masking is non-zero).
  - `cheri_cause_o` = the highest-priority cause code.
  - `cheri_fault_addr_o` = the stored address.
  - When `cheri_err_o` is low, `cheri_cause_o` and `cheri_fault_addr_o` are 0.
- **Protocol errors.** `protocol_err_o` pulses in the cycle after either event:
  - `data_rvalid_i` with `count == 0`: the response is ignored and state is unchanged;
  - a grant while `count == MaxOutstanding` with no `data_rvalid_i` in the same cycle: the grant is dropped.

## Timing
- **Reset.** While `rst_i` is high, immediately and asynchronously:
  - FIFO is empty, pointers are 0, `pend_valid_q=0`, `count=0`;
  - `req_allowed_o=1`;
  - `cheri_err_o=0`, `cheri_cause_o=0`, `cheri_fault_addr_o=0`, `protocol_err_o=0`.
- **Reset mid-transaction** discards all queued entries. A response arriving after reset release is a protocol error.
- **Output paths.**
  - `cheri_err_o`, `cheri_cause_o` and `cheri_fault_addr_o` are combinational from the FIFO head or bypass plus `data_rvalid_i`. They have zero added latency relative to the response.
  - `req_allowed_o` is combinational from registered `count` only, with no path from `data_gnt_i`.
- **Earliest response.** `data_rvalid_i` may first arrive in N+1. The bypass covers this case.
- **Full boundary.** A grant and an rvalid in the same cycle at full is legal: `count` stays unchanged.

## Test plan
- **Single faulting load.**
  - Stimulus: grant at `addr=0x1000`; the next cycle `cheri_mem_exc_i` has only LENGTH set; rvalid in N+2.
  - Required: `cheri_err_o=1`, `cheri_cause_o=0x01`, `cheri_fault_addr_o=0x1000`.
- **Bypass.**
  - Stimulus: grant at 0x2004; in N+1, TAG and LENGTH are set and rvalid is high.
  - Required: cause 0x02, addr 0x2004, FIFO stays empty.
- **Back-to-back ordering, MaxOutstanding=2.**
  - Stimulus: grants at 0x10 (clean) and 0x14 (SEAL); rvalids two cycles later.
  - Required: first response `cheri_err_o=0` with outputs 0; second response cause 0x03, addr 0x14.
  - Required: `req_allowed_o=0` while `count=2`.
- **Flow limit and pointer wrap-around.**
  - Stimulus: five transactions at full occupancy, each with a simultaneous grant and rvalid.
  - Required: no `protocol_err_o`; addresses return in order.
- **Protocol misuse.**
  - Stimulus: rvalid with `count=0`; separately, a grant at full with no rvalid.
  - Required: `protocol_err_o` pulses for one cycle each time; `count` is unchanged.
- **Instruction port and reset.**
  - Stimulus: with `DataMem=0`, a response whose vector has only PERMIT_STORE set.
  - Required: `cheri_err_o=0`.
  - Stimulus: assert `rst_i` with 2 entries outstanding.
  - Required: `count=0` and `req_allowed_o=1` immediately.

Source files
------------

// File: rtl/ibex_cheri_mem_exc_tracker.sv
// CHERI memory exception tracker: queues the checker's registered exception vector and
// request address per outstanding bus transaction and releases a prioritised cause on rvalid.
package ibex_pkg;
  localparam int unsigned CheriExcWidth = 6;

  localparam int unsigned TAG_VIOLATION            = 0;
  localparam int unsigned SEAL_VIOLATION           = 1;
  localparam int unsigned PERMIT_EXECUTE_VIOLATION = 2;
  localparam int unsigned PERMIT_LOAD_VIOLATION    = 3;
  localparam int unsigned PERMIT_STORE_VIOLATION   = 4;
  localparam int unsigned LENGTH_VIOLATION         = 5;

  localparam logic [4:0] CHERI_CAUSE_TAG    = 5'h02;
  localparam logic [4:0] CHERI_CAUSE_SEAL   = 5'h03;
  localparam logic [4:0] CHERI_CAUSE_EXEC   = 5'h11;
  localparam logic [4:0] CHERI_CAUSE_LOAD   = 5'h12;
  localparam logic [4:0] CHERI_CAUSE_STORE  = 5'h13;
  localparam logic [4:0] CHERI_CAUSE_LENGTH = 5'h01;
endpackage

module ibex_cheri_mem_exc_tracker
  import ibex_pkg::*;
#(
  parameter bit          DataMem        = 1'b1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_req_i,
  input  logic                     data_gnt_i,
  input  logic [31:0]              data_addr_i,
  input  logic                     data_rvalid_i,
  input  logic [CheriExcWidth-1:0] cheri_mem_exc_i,
  output logic                     req_allowed_o,
  output logic                     cheri_err_o,
  output logic [4:0]               cheri_cause_o,
  output logic [31:0]              cheri_fault_addr_o,
  output logic                     protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  // The instruction port never issues stores, so a store-permission fault there is spurious.
  localparam logic [CheriExcWidth-1:0] ExcMask =
      DataMem ? {CheriExcWidth{1'b1}} : ~(CheriExcWidth'(1) << PERMIT_STORE_VIOLATION);

  logic                     pend_valid_q, pend_valid_d;
  logic [31:0]              pend_addr_q, pend_addr_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                     protocol_err_q, protocol_err_d;
  logic [CheriExcWidth-1:0] mem_exc_q  [MaxOutstanding];
  logic [CheriExcWidth-1:0] mem_exc_d  [MaxOutstanding];
  logic [31:0]              mem_addr_q [MaxOutstanding];
  logic [31:0]              mem_addr_d [MaxOutstanding];

  logic                     grant, grant_ok, rvalid_ok;
  logic                     fifo_empty, bypass, fifo_wr, fifo_rd;
  logic [CntW-1:0]          count;
  logic [CheriExcWidth-1:0] sel_exc, masked_exc;
  logic [31:0]              sel_addr;
  logic [4:0]               cause;
  logic                     err;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign count         = fifo_cnt_q + CntW'(pend_valid_q);
  assign req_allowed_o = (count < MaxCnt);

  assign grant      = data_req_i & data_gnt_i;
  // At full a grant is only taken when a response frees a slot in the same cycle.
  assign grant_ok   = grant & ((count < MaxCnt) | data_rvalid_i);
  assign rvalid_ok  = data_rvalid_i & (count != '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  // With an empty FIFO and a non-zero count, the only outstanding entry is the one in capture.
  assign bypass     = rvalid_ok & fifo_empty;
  assign fifo_wr    = pend_valid_q & ~bypass;
  assign fifo_rd    = rvalid_ok & ~fifo_empty;

  always_comb begin
    pend_valid_d   = grant_ok;
    pend_addr_d    = grant_ok ? data_addr_i : pend_addr_q;
    wr_ptr_d       = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d       = fifo_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d     = fifo_cnt_q;
    mem_exc_d      = mem_exc_q;
    mem_addr_d     = mem_addr_q;
    protocol_err_d = (data_rvalid_i & (count == '0)) |
                     (grant & (count == MaxCnt) & ~data_rvalid_i);
    unique case ({fifo_wr, fifo_rd})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (fifo_wr) begin
      mem_exc_d[wr_ptr_q]  = cheri_mem_exc_i;
      mem_addr_d[wr_ptr_q] = pend_addr_q;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_addr_q    <= pend_addr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    mem_exc_q  <= mem_exc_d;
    mem_addr_q <= mem_addr_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_exc    = fifo_empty ? cheri_mem_exc_i : mem_exc_q[rd_ptr_q];
    sel_addr   = fifo_empty ? pend_addr_q : mem_addr_q[rd_ptr_q];
    masked_exc = sel_exc & ExcMask;
    cause      = '0;
    if      (masked_exc[TAG_VIOLATION])            cause = CHERI_CAUSE_TAG;
    else if (masked_exc[SEAL_VIOLATION])           cause = CHERI_CAUSE_SEAL;
    else if (masked_exc[PERMIT_EXECUTE_VIOLATION]) cause = CHERI_CAUSE_EXEC;
    else if (masked_exc[PERMIT_LOAD_VIOLATION])    cause = CHERI_CAUSE_LOAD;
    else if (masked_exc[PERMIT_STORE_VIOLATION])   cause = CHERI_CAUSE_STORE;
    else if (masked_exc[LENGTH_VIOLATION])         cause = CHERI_CAUSE_LENGTH;
  end

  assign err                = rvalid_ok & (|masked_exc);
  assign cheri_err_o        = err;
  assign cheri_cause_o      = err ? cause : 5'h00;
  assign cheri_fault_addr_o = err ? sel_addr : 32'h0;
  assign protocol_err_o     = protocol_err_q;

endmodule

// File: tb/tb_ibex_cheri_mem_exc_tracker.sv
// Bench for ibex_cheri_mem_exc_tracker: a data-port and an instruction-port instance share
// stimulus and are checked every cycle against a queue-based transaction model.
module tb_ibex_cheri_mem_exc_tracker;
  import ibex_pkg::*;

  localparam int unsigned W   = CheriExcWidth;
  localparam int unsigned MAX = 2;

  localparam logic [W-1:0] B_TAG    = W'(1) << TAG_VIOLATION;
  localparam logic [W-1:0] B_SEAL   = W'(1) << SEAL_VIOLATION;
  localparam logic [W-1:0] B_LEN    = W'(1) << LENGTH_VIOLATION;
  localparam logic [W-1:0] B_PSTORE = W'(1) << PERMIT_STORE_VIOLATION;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          data_req_i, data_gnt_i, data_rvalid_i;
  logic [31:0]   data_addr_i;
  logic [W-1:0]  cheri_mem_exc_i;

  logic          d_allowed, d_err, d_perr;
  logic [4:0]    d_cause;
  logic [31:0]   d_addr;
  logic          i_allowed, i_err, i_perr;
  logic [4:0]    i_cause;
  logic [31:0]   i_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_cheri_mem_exc_tracker #(.DataMem(1'b1), .MaxOutstanding(MAX)) u_dmem (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(data_req_i), .data_gnt_i(data_gnt_i),
    .data_addr_i(data_addr_i), .data_rvalid_i(data_rvalid_i), .cheri_mem_exc_i(cheri_mem_exc_i),
    .req_allowed_o(d_allowed), .cheri_err_o(d_err), .cheri_cause_o(d_cause),
    .cheri_fault_addr_o(d_addr), .protocol_err_o(d_perr)
  );

  ibex_cheri_mem_exc_tracker #(.DataMem(1'b0), .MaxOutstanding(MAX)) u_imem (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(data_req_i), .data_gnt_i(data_gnt_i),
    .data_addr_i(data_addr_i), .data_rvalid_i(data_rvalid_i), .cheri_mem_exc_i(cheri_mem_exc_i),
    .req_allowed_o(i_allowed), .cheri_err_o(i_err), .cheri_cause_o(i_cause),
    .cheri_fault_addr_o(i_addr), .protocol_err_o(i_perr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0]  addr;
    logic [W-1:0] exc;
    bit           have_exc;
  } txn_t;

  txn_t q[$];
  bit   exp_perr = 1'b0;

  int unsigned prio_bit  [6] = '{TAG_VIOLATION, SEAL_VIOLATION, PERMIT_EXECUTE_VIOLATION,
                                 PERMIT_LOAD_VIOLATION, PERMIT_STORE_VIOLATION, LENGTH_VIOLATION};
  logic [4:0]  prio_code [6] = '{5'h02, 5'h03, 5'h11, 5'h12, 5'h13, 5'h01};

  // First set bit in priority order wins; store faults do not exist on the instruction port.
  task automatic resolve(input logic [W-1:0] vec, input bit data_mem,
                         output bit err, output logic [4:0] cause);
    err   = 1'b0;
    cause = 5'h00;
    for (int k = 0; k < 6; k++) begin
      if (!err && vec[prio_bit[k]] && (data_mem || prio_bit[k] != PERMIT_STORE_VIOLATION)) begin
        err   = 1'b1;
        cause = prio_code[k];
      end
    end
  endtask

  bit           m_resp, m_derr, m_ierr, m_grant;
  logic [4:0]   m_dcause, m_icause;
  logic [31:0]  m_addr;
  logic [W-1:0] m_vec;
  int           m_sz;
  txn_t         m_t;

  always @(negedge clk_i) begin
    #2;
    if (rst_i) begin
      check("rst allowed", 32'(d_allowed), 32'd1);
      check("rst err",     32'(d_err),     32'd0);
      check("rst cause",   32'(d_cause),   32'd0);
      check("rst addr",    d_addr,         32'd0);
      check("rst perr",    32'(d_perr),    32'd0);
      check("rst i_err",   32'(i_err),     32'd0);
      q.delete();
      exp_perr = 1'b0;
    end else begin
      m_sz = q.size();
      check("d perr",    32'(d_perr),    32'(exp_perr));
      check("i perr",    32'(i_perr),    32'(exp_perr));
      check("d allowed", 32'(d_allowed), 32'(m_sz < MAX));
      check("i allowed", 32'(i_allowed), 32'(m_sz < MAX));

      m_resp = data_rvalid_i && (m_sz > 0);
      m_derr = 1'b0; m_ierr = 1'b0; m_dcause = '0; m_icause = '0; m_addr = '0;
      if (m_resp) begin
        m_vec  = q[0].have_exc ? q[0].exc : cheri_mem_exc_i;
        m_addr = q[0].addr;
        resolve(m_vec, 1'b1, m_derr, m_dcause);
        resolve(m_vec, 1'b0, m_ierr, m_icause);
      end
      check("d err",   32'(d_err),   32'(m_derr));
      check("d cause", 32'(d_cause), 32'(m_dcause));
      check("d addr",  d_addr,       m_derr ? m_addr : 32'h0);
      check("i err",   32'(i_err),   32'(m_ierr));
      check("i cause", 32'(i_cause), 32'(m_icause));
      check("i addr",  i_addr,       m_ierr ? m_addr : 32'h0);

      // Advance to the state after the coming rising edge.
      if (m_sz > 0 && !q[m_sz-1].have_exc) begin
        m_t = q[m_sz-1];
        m_t.exc = cheri_mem_exc_i;
        m_t.have_exc = 1'b1;
        q[m_sz-1] = m_t;
      end
      m_grant  = data_req_i && data_gnt_i;
      exp_perr = (data_rvalid_i && m_sz == 0) || (m_grant && m_sz == MAX && !data_rvalid_i);
      if (m_resp) void'(q.pop_front());
      if (m_grant && (m_sz < MAX || data_rvalid_i)) begin
        m_t.addr = data_addr_i;
        m_t.exc = '0;
        m_t.have_exc = 1'b0;
        q.push_back(m_t);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit g, input logic [31:0] a, input bit rv, input logic [W-1:0] e);
    @(negedge clk_i);
    data_req_i      = g;
    data_gnt_i      = g;
    data_addr_i     = g ? a : $urandom;
    data_rvalid_i   = rv;
    cheri_mem_exc_i = e;
    #3;
  endtask

  function automatic logic [W-1:0] rand_exc();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'(1) << $urandom_range(0, W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_i = 1'b1;
    data_req_i = 0; data_gnt_i = 0; data_addr_i = 0; data_rvalid_i = 0; cheri_mem_exc_i = 0;
    #1;
    check("async reset allowed", 32'(d_allowed), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Single faulting load: LENGTH only, response two cycles after the grant.
    step(1, 32'h1000, 0, '0);
    step(0, 0, 0, B_LEN);
    step(0, 0, 1, '0);
    check("load err",   32'(d_err),   32'd1);
    check("load cause", 32'(d_cause), 32'h01);
    check("load addr",  d_addr,       32'h1000);

    // Bypass: response in the cycle right after the grant.
    step(1, 32'h2004, 0, '0);
    step(0, 0, 1, B_TAG | B_LEN);
    check("bypass cause", 32'(d_cause), 32'h02);
    check("bypass addr",  d_addr,       32'h2004);
    step(0, 0, 0, '0);
    check("bypass empty allowed", 32'(d_allowed), 32'd1);

    // Back-to-back ordering.
    step(1, 32'h10, 0, '0);
    step(1, 32'h14, 0, '0);
    step(0, 0, 0, B_SEAL);
    check("b2b full allowed", 32'(d_allowed), 32'd0);
    step(0, 0, 1, B_TAG);
    check("b2b first err",   32'(d_err),   32'd0);
    check("b2b first cause", 32'(d_cause), 32'd0);
    check("b2b first addr",  d_addr,       32'd0);
    step(0, 0, 1, '0);
    check("b2b second cause", 32'(d_cause), 32'h03);
    check("b2b second addr",  d_addr,       32'h14);

    // Full occupancy with grant + rvalid every cycle; pointers wrap.
    step(1, 32'h100, 0, '0);
    step(1, 32'h104, 0, B_LEN);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h108 + 32'(4 * i), 1, B_LEN);
      check("wrap addr", d_addr, 32'h100 + 32'(4 * i));
      check("wrap perr", 32'(d_perr), 32'd0);
    end
    step(0, 0, 1, B_LEN);
    check("wrap drain0", d_addr, 32'h114);
    step(0, 0, 1, '0);
    check("wrap drain1", d_addr, 32'h118);

    // Protocol misuse: rvalid with nothing outstanding, then a grant at full.
    step(0, 0, 1, B_TAG);
    check("orphan rvalid err", 32'(d_err), 32'd0);
    step(0, 0, 0, '0);
    check("orphan perr pulse", 32'(d_perr), 32'd1);
    step(0, 0, 0, '0);
    check("orphan perr clear", 32'(d_perr), 32'd0);
    step(1, 32'h200, 0, '0);
    step(1, 32'h204, 0, '0);
    step(1, 32'h208, 0, '0);
    step(0, 0, 0, '0);
    check("overgrant perr", 32'(d_perr), 32'd1);
    step(0, 0, 1, '0);
    check("overgrant perr clear", 32'(d_perr), 32'd0);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    check("overgrant count kept", 32'(d_perr), 32'd0);
    check("overgrant drained",    32'(d_allowed), 32'd1);

    // Store fault is only visible on the data port.
    step(1, 32'h3000, 0, '0);
    step(0, 0, 0, B_PSTORE);
    step(0, 0, 1, '0);
    check("store d cause", 32'(d_cause), 32'h13);
    check("store i err",   32'(i_err),   32'd0);

    // Reset with two entries outstanding.
    step(1, 32'h40, 0, '0);
    step(1, 32'h44, 0, '0);
    step(0, 0, 0, '0);
    check("pre-reset allowed", 32'(d_allowed), 32'd0);
    #1 rst_i = 1'b1;
    data_rvalid_i = 1'b1;
    #1;
    check("mid reset allowed", 32'(d_allowed), 32'd1);
    check("mid reset err",     32'(d_err),     32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #3;
    step(0, 0, 0, '0);
    check("post reset perr", 32'(d_perr), 32'd1);

    // Randomised traffic, including orphan responses and over-grants.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      data_req_i      = ($urandom_range(0, 9) < 6);
      data_gnt_i      = ($urandom_range(0, 9) < 7);
      data_addr_i     = $urandom;
      data_rvalid_i   = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      cheri_mem_exc_i = rand_exc();
      #3;
    end

    repeat (3) step(0, 0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
